// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: assembles a row-major element stream into a packed
// M*N*nBits matrix bus (element (0,0) in the MSBs) with valid/ready on both
// sides and a one-cycle frame_err pulse when in_last disagrees with the count.
// Optional double buffering: define MATRIX_LOADER_DBUF_EN.
module matrix_stream_loader #(
  parameter int unsigned M     = 2,
  parameter int unsigned N     = 2,
  parameter int unsigned nBits = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [nBits-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  output logic [M*N*nBits-1:0]   out_matrix,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_err
);

  localparam int unsigned NEL = M * N;
  localparam int unsigned W   = NEL * nBits;
  localparam int unsigned IW  = (NEL > 1) ? $clog2(NEL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NEL - 1);

  // FILL: accepting elements. FULL: single-buffer -> output held;
  // double-buffer -> assembly buffer complete and waiting for handoff.
  typedef enum logic {FILL, FULL} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             frame_err_q, frame_err_d;
  logic [W-1:0]     mat_q, mat_d;
  logic             accept;
  logic             at_last;

  // Write element d into slot k of matrix m using the datapath packing.
  function automatic logic [W-1:0] put_slot(input logic [W-1:0]     m,
                                            input logic [IW-1:0]    k,
                                            input logic [nBits-1:0] d);
    logic [W-1:0] r;
    r = m;
    for (int unsigned s = 0; s < NEL; s++) begin
      if (k == IW'(s)) r[(NEL-1-s)*nBits +: nBits] = d;
    end
    return r;
  endfunction

  assign accept  = in_valid && in_ready;
  assign at_last = (idx_q == LAST_IDX);

  assign out_matrix = mat_q;
  assign frame_err  = frame_err_q;
  assign in_ready   = (state_q == FILL);

`ifdef MATRIX_LOADER_DBUF_EN

  logic [W-1:0] asm_q, asm_d;
  logic         ov_q, ov_d;
  logic         out_free;
  logic [W-1:0] asm_next;

  assign out_valid = ov_q;
  // Output register can take a new matrix this cycle.
  assign out_free  = !ov_q || out_ready;

  // Next-state: assembly into asm buffer, handoff to the output register.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    asm_d       = asm_q;
    mat_d       = mat_q;
    ov_d        = ov_q && !out_ready;
    asm_next    = put_slot(asm_q, idx_q, in_data);
    case (state_q)
      FILL: begin
        if (accept) begin
          asm_d = asm_next;
          if (at_last) begin
            idx_d       = '0;
            frame_err_d = !in_last;
            // Completed matrix bypasses straight into an empty/draining output.
            if (out_free) begin
              mat_d = asm_next;
              ov_d  = 1'b1;
            end else begin
              state_d = FULL;
            end
          end else if (in_last) begin
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      FULL: begin
        if (out_free) begin
          mat_d   = asm_q;
          ov_d    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      asm_q       <= '0;
      mat_q       <= '0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      asm_q       <= asm_d;
      mat_q       <= mat_d;
      ov_q        <= ov_d;
    end
  end

`else

  assign out_valid = (state_q == FULL);

  // Next-state: fill out_matrix in place, hold it while FULL.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    mat_d       = mat_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          mat_d = put_slot(mat_q, idx_q, in_data);
          if (at_last) begin
            idx_d       = '0;
            frame_err_d = !in_last;
            state_d     = FULL;
          end else if (in_last) begin
            // Early in_last: drop the partial matrix, stale slots remain.
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      mat_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      mat_q       <= mat_d;
    end
  end

`endif

endmodule

// File: doc/matrix_stream_loader.md
Name: matrix_stream_loader

Overview:
- Upstream feeder for the packed-matrix datapath (transpose, multiplier, pseudoinverse stages).
- Accepts matrix elements one per handshake, row-major, over a valid/ready stream.
- Assembles them into a registered flat M*N*nBits bus and presents it with a valid/ready output handshake.
- Output bus uses the datapath packing: element (i,j) occupies bits [M*N*nBits-(N*i+j)*nBits-1 : M*N*nBits-(N*i+j)*nBits-nBits], so element (0,0) sits in the MSBs.

Parameters:
M, 2, number of rows
N, 2, number of columns
nBits, 2, bits per element (unsigned, stored verbatim)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  nBits  element value
in_valid  input  1  in_data/in_last valid
in_ready  output  1  loader can accept an element
in_last  input  1  marks the final element of a matrix (index M*N-1)
out_matrix  output  M*N*nBits  assembled packed matrix, registered
out_valid  output  1  out_matrix holds a complete matrix
out_ready  input  1  consumer takes the matrix
frame_err  output  1  one-cycle pulse on in_last/count mismatch

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_valid=0, out_matrix=0, frame_err=0, element index idx=0, state FILL. in_ready=1 in the first cycle after reset deassertion.
- Reset mid-operation: any partial or held matrix is discarded.
- Accept: an element is taken on a rising edge with in_valid && in_ready. It is written into slot idx, using the packing above with i=idx/N, j=idx%N.
- Index wrap: idx increments per accept and wraps to 0 after M*N-1.
- FILL (in_ready=1, out_valid=0): accept elements. When the accepted element has idx==M*N-1, go to FULL; out_valid=1 the next cycle. Latency from last input handshake to out_valid is 1 cycle.
- FULL (in_ready=0, out_valid=1): out_matrix stays stable. On out_valid && out_ready, go to FILL with idx=0 and out_valid=0 the next cycle. Holding out_ready high gives one matrix per M*N+1 cycles.
- Framing check on every accepted element:
  - in_last=1 with idx<M*N-1: frame_err pulses the next cycle. The partial matrix is discarded (slots need not be cleared), idx=0, and the state stays FILL.
  - idx==M*N-1 with in_last=0: frame_err pulses. The matrix still completes normally.
  - in_last matching the count: no pulse.
- in_valid in FULL is ignored (in_ready=0); in_data may change freely.
- out_ready while out_valid=0 has no effect.
- Slots not rewritten since a discard keep stale data. The spec guarantees only full, correctly counted fills.
- Degenerate M*N==1: every accept completes a matrix; in_last is expected to be 1 on every element.

Optional Feature:
MATRIX_LOADER_DBUF_EN
- Defined: adds a separate assembly buffer plus the output register (double buffering).
  - in_ready stays 1 while out_valid=1.
  - A completed assembly transfers to out_matrix when the output is empty or is consumed in the same cycle. out_valid then stays 1 with no gap, giving one matrix per M*N cycles.
  - If assembly completes while the output is still held and not consumed: in_ready=0 until the handoff cycle, then the next fill resumes.
  - Framing rules are unchanged.
- Undefined: single-buffer FILL/FULL behaviour as above. No extra storage is inferred.

Test Plan:
- M=2,N=3,nBits=4, out_ready=1; stream 1,2,3,4,5,6 with in_last on 6 -> out_valid rises 1 cycle after last accept, out_matrix=24'h123456, frame_err stays 0.
- Same config, out_ready=0 for 10 cycles after completion -> in_ready=0 and out_matrix stable at 24'h123456 throughout; 7th element offered is not taken until the cycle after out_ready=1.
- Stream 9,8 with in_last on 8, then 1..6 correct -> frame_err pulse once, first output 24'h123456.
- Stream 1..6 with in_last=0 on 6 -> frame_err pulse, out_matrix=24'h123456 still delivered.
- Assert rst after 4 elements accepted, then stream A..F -> out_valid=0 during and after reset, next output 24'hABCDEF.
- MATRIX_LOADER_DBUF_EN defined, continuous in_valid, out_ready=1 -> in_ready never drops, out_valid continuous, one new matrix every 6 cycles.
